ls_sequencer: RTL and testbench
===============================

# ls_sequencer

Load/store sequencer that runs one memory access per decoded load/store instruction. It computes the effective address from base and offset under P/U/W/B control, drives a req/ack handshake to data memory, and stalls the pipeline while the access is outstanding. On completion it returns load data and updated base values to the register file. It sits between decode/ALU operand generation and the data-memory port, replacing the single-cycle `mem_en`/`mem_wr` strobe with a sequenced access.

## Interface
- `TIMEOUT`, 16: cycles `mem_req` may stay high without `mem_ack` before the access is aborted; legal range 1..255.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ls_valid` input 1: a load/store is presented; sampled only in IDLE.
- `ls_load` / `ls_pre` / `ls_up` / `ls_wb` / `ls_byte` input 1 each: L, P, U, W, B instruction bits.
- `ls_base` input 32: Rn value.
- `ls_offset` input 32: offset, already immediate- or shift-generated.
- `ls_rn`, `ls_rd` input 4: base and data register addresses.
- `ls_sdata` input 32: store data (Rd value).
- `stall` output 1: holds fetch/decode.
- `mem_req` / `mem_wr` output 1: request, write enable.
- `mem_addr` output 32: word-aligned address with `[1:0]` = 0.
- `mem_wdata` output 32; `mem_be` output 4: byte enables.
- `mem_ack` input 1: access complete; valid only while `mem_req` = 1.
- `mem_rdata` input 32: valid in the `mem_ack` cycle.
- `rd_we` output 1; `rd_waddr` output 4; `rd_wdata` output 32: load result write port.
- `rn_we` output 1; `rn_waddr` output 4; `rn_wdata` output 32: base writeback port.
- `ls_err` output 1: one-cycle pulse on alignment error or timeout.

## Operation
- States: IDLE, REQ, DONE.
- IDLE and `ls_valid`:
  - `sum` = `ls_up` ? base+offset : base−offset, modulo 2^32, with wrap ignored.
  - Effective address `ea` = `ls_pre` ? `sum` : `ls_base`.
  - Base writeback is enabled when `!ls_pre || ls_wb`.
  - Register all fields.
  - Word access with `ea[1:0]` ≠ 0: go to DONE with the error flag set; no memory access.
  - Otherwise go to REQ.
- REQ:
  - `mem_req` = 1; `mem_addr`, `mem_wr`, `mem_wdata` and `mem_be` are held stable.
  - Byte store: `mem_wdata` = `{4{sdata[7:0]}}`, `mem_be` = one-hot of `ea[1:0]`.
  - Word store: `mem_be` = 4'hF. Load: `mem_be` = lane(s) requested, `mem_wr` = 0.
  - Wait counter clears on REQ entry and increments each cycle without ack.
  - `mem_ack`: capture `mem_rdata` and go to DONE.
  - Counter reaches `TIMEOUT`: go to DONE with the error flag set.
- DONE, exactly one cycle:
  - Error: `ls_err` = 1, `rd_we` = `rn_we` = 0.
  - Otherwise, for a load: `rd_we` = 1. Byte load returns the selected lane zero-extended to 32 bits.
  - Otherwise, if writeback is enabled: `rn_we` = 1, `rn_wdata` = `sum`.
  - Load with `rd` == `rn` and writeback enabled: load wins and `rn_we` = 0.
  - Next state is IDLE.
- `stall` = (IDLE && `ls_valid`) || REQ. It is combinational and low in DONE, so the pipeline advances at the DONE edge.

## Timing
- Reset: state = IDLE, counter = 0, and all outputs 0, including `stall`, `mem_req`, `rd_we`, `rn_we` and `ls_err`; data outputs are also 0.
- Minimum latency is 3 cycles: valid in cycle 0, `mem_req` in cycle 1 with ack in that same cycle, writeback in cycle 2.
- Alignment error: 2 cycles, with `ls_err` in cycle 1.
- Timeout: `ls_err` appears in cycle `TIMEOUT`+1 after the valid cycle.
- `ls_valid` during REQ or DONE is ignored; upstream holds it because `stall` is high.
- `ls_valid` high in the DONE-to-IDLE cycle is accepted in the following IDLE cycle, so back-to-back accesses cost one IDLE cycle.
- `mem_ack` outside REQ is ignored.
- `rst` in REQ drops `mem_req` at that edge and suppresses all writebacks and `ls_err`.

## Structure
- Package `ls_pkg` holds:
  - the state enum;
  - byte-lane constants `BE_WORD` = 4'hF and `BE_LANE0..3`;
  - the timeout counter width `$clog2(256)`.
- One sub-module, `ls_lane_align` (combinational). It performs byte extraction and zero-extension for loads, and byte replication plus `be` generation for stores.
- The FSM, address adder and counter live in `ls_sequencer`.

## Test plan
- Word load: pre, up, no wb; base = 0x1000, offset = 0x10; ack in the first REQ cycle with rdata = 0xDEADBEEF.
  - `mem_addr` = 0x1010.
  - `rd_we` with 0xDEADBEEF 2 cycles after valid; `rn_we` = 0; `stall` high for exactly 2 cycles.
- Byte store: post-index, down; base = 0x2003, offset = 4, sdata = 0x12345678.
  - `mem_addr` = 0x2000, `mem_be` = 4'b1000, `mem_wdata` = 0x78787878.
  - `rn_wdata` = 0x1FFF.
- Byte load: `ea` = 0x3001, rdata = 0xAABBCCDD → `rd_wdata` = 0x000000CC.
- Load with writeback, rd = rn = 5 → only `rd_we`; `rn_we` stays 0.
- Edge cases:
  - Word load at 0x4002: no `mem_req`, `ls_err` pulse, no writes.
  - `TIMEOUT` = 4 with no ack: `ls_err` in cycle 5, `mem_req` deasserted.
- Reset asserted in the second REQ cycle: `mem_req` = 0 and `stall` = 0 next cycle, with no writeback. A following access then completes normally.

Source files
------------

// File: rtl/ls_pkg.sv
// Shared types and constants for the load/store sequencer.
package ls_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } ls_state_e;

  localparam logic [3:0] BE_WORD  = 4'hF;
  localparam logic [3:0] BE_LANE0 = 4'b0001;
  localparam logic [3:0] BE_LANE1 = 4'b0010;
  localparam logic [3:0] BE_LANE2 = 4'b0100;
  localparam logic [3:0] BE_LANE3 = 4'b1000;

  localparam int unsigned CNT_W = $clog2(256);

  // Access fields latched when a load/store is accepted
  typedef struct packed {
    logic        load;
    logic        byte_acc;
    logic        wb;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [1:0]  ea_lo;
    logic [31:0] sum;
  } ls_acc_t;

  // One-hot byte enable for a byte lane
  function automatic logic [3:0] lane_be(input logic [1:0] lo);
    logic [3:0] be;
    unique case (lo)
      2'd0: be = BE_LANE0;
      2'd1: be = BE_LANE1;
      2'd2: be = BE_LANE2;
      default: be = BE_LANE3;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ls_lane_align.sv
// Byte-lane steering: store replication/enables and load extraction.
module ls_lane_align
  import ls_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic        byte_acc,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  // Word accesses pass straight through; byte accesses use the addressed lane
  always_comb begin
    be    = BE_WORD;
    wdata = sdata;
    ldata = rdata;
    if (byte_acc) begin
      be    = lane_be(addr_lo);
      wdata = {4{sdata[7:0]}};
      unique case (addr_lo)
        2'd0: ldata = {24'd0, rdata[7:0]};
        2'd1: ldata = {24'd0, rdata[15:8]};
        2'd2: ldata = {24'd0, rdata[23:16]};
        default: ldata = {24'd0, rdata[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/ls_sequencer.sv
// Sequenced load/store: address generation, memory handshake, writeback.
module ls_sequencer
  import ls_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ls_valid,
  input  logic        ls_load,
  input  logic        ls_pre,
  input  logic        ls_up,
  input  logic        ls_wb,
  input  logic        ls_byte,
  input  logic [31:0] ls_base,
  input  logic [31:0] ls_offset,
  input  logic [3:0]  ls_rn,
  input  logic [3:0]  ls_rd,
  input  logic [31:0] ls_sdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rd_we,
  output logic [3:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        rn_we,
  output logic [3:0]  rn_waddr,
  output logic [31:0] rn_wdata,
  output logic        ls_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  ls_state_e        state_q, state_n;
  ls_acc_t          acc_q, acc_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic [31:0] sum_c, ea_c;
  logic [1:0]  align_lo;
  logic        align_byte;
  logic [3:0]  align_be;
  logic [31:0] align_wdata, align_ldata;

  logic        mem_req_n, mem_wr_n;
  logic [31:0] mem_addr_n, mem_wdata_n;
  logic [3:0]  mem_be_n;
  logic        rd_we_n, rn_we_n, ls_err_n;
  logic [3:0]  rd_waddr_n, rn_waddr_n;
  logic [31:0] rd_wdata_n, rn_wdata_n;

  // Indexed sum (wraps mod 2^32) and effective address of the presented access
  always_comb begin
    sum_c = ls_up ? (ls_base + ls_offset) : (ls_base - ls_offset);
    ea_c  = ls_pre ? sum_c : ls_base;
  end

  // Lane steering sees live operands in IDLE and the latched access afterwards
  assign align_lo   = (state_q == ST_IDLE) ? ea_c[1:0] : acc_q.ea_lo;
  assign align_byte = (state_q == ST_IDLE) ? ls_byte : acc_q.byte_acc;

  ls_lane_align u_align (
    .addr_lo  (align_lo),
    .byte_acc (align_byte),
    .sdata    (ls_sdata),
    .rdata    (mem_rdata),
    .be       (align_be),
    .wdata    (align_wdata),
    .ldata    (align_ldata)
  );

  // Hold fetch/decode while an access is being accepted or is outstanding
  assign stall = ((state_q == ST_IDLE) && ls_valid) || (state_q == ST_REQ);

  // Next state, latched access and next values of the registered outputs
  always_comb begin
    state_n     = state_q;
    acc_n       = acc_q;
    cnt_n       = cnt_q;
    mem_req_n   = 1'b0;
    mem_wr_n    = 1'b0;
    mem_be_n    = 4'h0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    rd_we_n     = 1'b0;
    rn_we_n     = 1'b0;
    ls_err_n    = 1'b0;
    rd_waddr_n  = rd_waddr;
    rd_wdata_n  = rd_wdata;
    rn_waddr_n  = rn_waddr;
    rn_wdata_n  = rn_wdata;

    unique case (state_q)
      ST_IDLE: begin
        if (ls_valid) begin
          acc_n.load     = ls_load;
          acc_n.byte_acc = ls_byte;
          acc_n.wb       = !ls_pre || ls_wb;
          acc_n.rn       = ls_rn;
          acc_n.rd       = ls_rd;
          acc_n.ea_lo    = ea_c[1:0];
          acc_n.sum      = sum_c;
          if (!ls_byte && (ea_c[1:0] != 2'b00)) begin
            state_n  = ST_DONE;
            ls_err_n = 1'b1;
          end else begin
            state_n     = ST_REQ;
            cnt_n       = '0;
            mem_req_n   = 1'b1;
            mem_wr_n    = !ls_load;
            mem_addr_n  = {ea_c[31:2], 2'b00};
            mem_wdata_n = align_wdata;
            mem_be_n    = align_be;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_n    = ST_DONE;
          rn_waddr_n = acc_q.rn;
          rn_wdata_n = acc_q.sum;
          if (acc_q.load) begin
            rd_we_n    = 1'b1;
            rd_waddr_n = acc_q.rd;
            rd_wdata_n = align_ldata;
            rn_we_n    = acc_q.wb && (acc_q.rn != acc_q.rd);
          end else begin
            rn_we_n = acc_q.wb;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_n  = ST_DONE;
          ls_err_n = 1'b1;
        end else begin
          cnt_n     = cnt_q + CNT_W'(1);
          mem_req_n = 1'b1;
          mem_wr_n  = mem_wr;
          mem_be_n  = mem_be;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, latched access, wait counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'h0;
      rd_we     <= 1'b0;
      rd_waddr  <= 4'd0;
      rd_wdata  <= 32'd0;
      rn_we     <= 1'b0;
      rn_waddr  <= 4'd0;
      rn_wdata  <= 32'd0;
      ls_err    <= 1'b0;
    end else begin
      state_q   <= state_n;
      acc_q     <= acc_n;
      cnt_q     <= cnt_n;
      mem_req   <= mem_req_n;
      mem_wr    <= mem_wr_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_be    <= mem_be_n;
      rd_we     <= rd_we_n;
      rd_waddr  <= rd_waddr_n;
      rd_wdata  <= rd_wdata_n;
      rn_we     <= rn_we_n;
      rn_waddr  <= rn_waddr_n;
      rn_wdata  <= rn_wdata_n;
      ls_err    <= ls_err_n;
    end
  end

endmodule

// File: tb/tb_ls_sequencer.sv
// Scoreboard bench for ls_sequencer with a transaction-level reference model.
module tb_ls_sequencer;

  localparam int unsigned TO    = 4;
  localparam int unsigned NOACK = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid, ls_load, ls_pre, ls_up, ls_wb, ls_byte;
  logic [31:0] ls_base, ls_offset, ls_sdata;
  logic [3:0]  ls_rn, ls_rd;
  logic        stall, mem_req, mem_wr, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rd_we, rn_we, ls_err;
  logic [3:0]  rd_waddr, rn_waddr;
  logic [31:0] rd_wdata, rn_wdata;

  always #5 clk = ~clk;

  ls_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ls_valid(ls_valid), .ls_load(ls_load), .ls_pre(ls_pre),
    .ls_up(ls_up), .ls_wb(ls_wb), .ls_byte(ls_byte), .ls_base(ls_base),
    .ls_offset(ls_offset), .ls_rn(ls_rn), .ls_rd(ls_rd), .ls_sdata(ls_sdata),
    .stall(stall), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rn_we(rn_we),
    .rn_waddr(rn_waddr), .rn_wdata(rn_wdata), .ls_err(ls_err)
  );

  typedef struct {
    logic load, pre, up, wb, byte_acc;
    logic [31:0] base, offset, sdata;
    logic [3:0] rn, rd;
    int unsigned dly;
  } txn_t;

  typedef struct {
    logic [31:0] addr, wdata;
    logic wr;
    logic [3:0] be;
  } req_exp_t;

  typedef struct {
    int stall_len;
    logic err, rd_we, rn_we;
    logic [3:0] rd_waddr, rn_waddr;
    logic [31:0] rd_wdata, rn_wdata;
  } rsp_exp_t;

  req_exp_t    req_q[$];
  rsp_exp_t    rsp_q[$];
  int unsigned dly_q[$];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] dev_mem [logic [29:0]];

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return {w[13:0], 2'b01, ~w[15:0]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] ref_read(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] dev_read(input logic [29:0] w);
    return dev_mem.exists(w) ? dev_mem[w] : init_word(w);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic load, pre, up, wb, byte_acc,
                              input logic [31:0] base, offset, sdata,
                              input logic [3:0] rn, rd, input int unsigned dly);
    txn_t t;
    t.load = load; t.pre = pre; t.up = up; t.wb = wb; t.byte_acc = byte_acc;
    t.base = base; t.offset = offset; t.sdata = sdata;
    t.rn = rn; t.rd = rd; t.dly = dly;
    return t;
  endfunction

  // Reference model: expected memory request and completion for one access
  task automatic model_push(input txn_t t, input bit abort);
    logic [31:0] sum, ea, word;
    logic        wbe, err;
    int unsigned lane;
    req_exp_t    rq;
    rsp_exp_t    rs;
    sum  = t.up ? t.base + t.offset : t.base - t.offset;
    ea   = t.pre ? sum : t.base;
    wbe  = !t.pre || t.wb;
    lane = ea % 4;
    err  = !t.byte_acc && (lane != 0);
    rs.stall_len = 0; rs.err = 0; rs.rd_we = 0; rs.rn_we = 0;
    rs.rd_waddr = 0; rs.rn_waddr = 0; rs.rd_wdata = 0; rs.rn_wdata = 0;
    if (err) begin
      rs.err = 1; rs.stall_len = 1;
    end else begin
      rq.addr  = ea & ~32'h3;
      rq.wr    = !t.load;
      rq.be    = t.byte_acc ? 4'(1 << lane) : 4'hF;
      rq.wdata = t.byte_acc ? {4{t.sdata[7:0]}} : t.sdata;
      req_q.push_back(rq);
      dly_q.push_back(t.dly);
      if (abort) begin
        rs.stall_len = 3;
      end else if (t.dly == NOACK) begin
        rs.err = 1; rs.stall_len = 1 + TO;
      end else begin
        rs.stall_len = 2 + t.dly;
        rs.rn_waddr  = t.rn;
        rs.rn_wdata  = sum;
        word = ref_read(ea[31:2]);
        if (t.load) begin
          rs.rd_we    = 1;
          rs.rd_waddr = t.rd;
          rs.rd_wdata = t.byte_acc ? ((word >> (8 * lane)) & 32'hFF) : word;
          rs.rn_we    = wbe && (t.rn != t.rd);
        end else begin
          rs.rn_we = wbe;
          if (t.byte_acc) word[8*lane +: 8] = t.sdata[7:0];
          else word = t.sdata;
          ref_mem[ea[31:2]] = word;
        end
      end
    end
    rsp_q.push_back(rs);
  endtask

  task automatic drive(input txn_t t);
    ls_valid = 1; ls_load = t.load; ls_pre = t.pre; ls_up = t.up; ls_wb = t.wb;
    ls_byte = t.byte_acc; ls_base = t.base; ls_offset = t.offset; ls_sdata = t.sdata;
    ls_rn = t.rn; ls_rd = t.rd;
  endtask

  // Present one access (called at posedge+1) and hold it until stall drops
  task automatic issue(input txn_t t);
    int cyc;
    model_push(t, 1'b0);
    drive(t);
    cyc = 0;
    @(negedge clk);
    while (stall !== 1'b0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (stall !== 1'b0) begin
      n_tests++; n_fail++;
      $display("FAIL stall_bound: stall still high after 40 cycles at %0t", $time);
    end
    @(posedge clk); #1;
    ls_valid = 0;
  endtask

  // Data memory responder: acks after the queued delay, random ack noise when idle
  int unsigned r_dly, r_cnt;
  bit          r_prev = 1'b0;
  logic [31:0] r_word;
  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      if (!r_prev) begin
        r_dly = (dly_q.size() > 0) ? dly_q.pop_front() : NOACK;
        r_cnt = 0;
      end else begin
        r_cnt++;
      end
      if (r_dly != NOACK && r_cnt == r_dly) begin
        mem_ack   = 1;
        mem_rdata = dev_read(mem_addr[31:2]);
        if (mem_wr) begin
          r_word = dev_read(mem_addr[31:2]);
          for (int i = 0; i < 4; i++)
            if (mem_be[i]) r_word[8*i +: 8] = mem_wdata[8*i +: 8];
          dev_mem[mem_addr[31:2]] = r_word;
        end
      end else begin
        mem_ack   = 0;
        mem_rdata = $urandom;
      end
    end else begin
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
    r_prev = (mem_req === 1'b1);
  end

  // Monitor: checks requests on assertion, holds while pending, completions on stall fall
  logic        m_stall_prev = 1'b0, m_req_prev = 1'b0, m_wr_prev;
  logic [31:0] m_addr_prev, m_wdata_prev;
  logic [3:0]  m_be_prev;
  int          m_run = 0;
  req_exp_t    m_rq;
  rsp_exp_t    m_rs;
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_req && !m_req_prev) begin
        if (req_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL req_unexpected: addr 0x%08h at %0t", mem_addr, $time);
        end else begin
          m_rq = req_q.pop_front();
          chk("req_addr", mem_addr, m_rq.addr);
          chk("req_wr", 32'(mem_wr), 32'(m_rq.wr));
          chk("req_be", 32'(mem_be), 32'(m_rq.be));
          if (m_rq.wr) chk("req_wdata", mem_wdata, m_rq.wdata);
        end
      end else if (mem_req) begin
        chk("req_hold", 32'(mem_addr != m_addr_prev || mem_be != m_be_prev ||
                            mem_wr != m_wr_prev || mem_wdata != m_wdata_prev), 32'd0);
      end
      if (!stall && m_stall_prev) begin
        if (rsp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rsp_unexpected: completion with empty queue at %0t", $time);
        end else begin
          m_rs = rsp_q.pop_front();
          chk("stall_len", 32'(m_run), 32'(m_rs.stall_len));
          chk("ls_err", 32'(ls_err), 32'(m_rs.err));
          chk("done_mem_req", 32'(mem_req), 32'd0);
          chk("rd_we", 32'(rd_we), 32'(m_rs.rd_we));
          if (m_rs.rd_we) begin
            chk("rd_waddr", 32'(rd_waddr), 32'(m_rs.rd_waddr));
            chk("rd_wdata", rd_wdata, m_rs.rd_wdata);
          end
          chk("rn_we", 32'(rn_we), 32'(m_rs.rn_we));
          if (m_rs.rn_we) begin
            chk("rn_waddr", 32'(rn_waddr), 32'(m_rs.rn_waddr));
            chk("rn_wdata", rn_wdata, m_rs.rn_wdata);
          end
        end
      end else begin
        chk("quiet_strobes", {29'd0, rd_we, rn_we, ls_err}, 32'd0);
      end
    end
    m_run        = stall ? m_run + 1 : 0;
    m_stall_prev = stall;
    m_req_prev   = mem_req;
    m_addr_prev  = mem_addr;
    m_wdata_prev = mem_wdata;
    m_be_prev    = mem_be;
    m_wr_prev    = mem_wr;
  end

  txn_t t;
  initial begin
    rst = 1; ls_valid = 0; ls_load = 0; ls_pre = 0; ls_up = 0; ls_wb = 0; ls_byte = 0;
    ls_base = 0; ls_offset = 0; ls_sdata = 0; ls_rn = 0; ls_rd = 0;
    mem_ack = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_strobes", {29'd0, rd_we, rn_we, ls_err}, 32'd0);
    chk("rst_wdata", rd_wdata | rn_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    mon_en = 1;

    ref_mem[30'h404] = 32'hDEADBEEF; dev_mem[30'h404] = 32'hDEADBEEF;
    ref_mem[30'hC00] = 32'hAABBCCDD; dev_mem[30'hC00] = 32'hAABBCCDD;
    // word load, byte store post-index down, byte load, load rd==rn with wb
    issue(mk(1, 1, 1, 0, 0, 32'h1000, 32'h10, 32'h0, 4'd2, 4'd1, 0));
    issue(mk(0, 0, 0, 0, 1, 32'h2003, 32'h4, 32'h12345678, 4'd6, 4'd7, 1));
    issue(mk(1, 1, 1, 0, 1, 32'h3000, 32'h1, 32'h0, 4'd8, 4'd9, 2));
    issue(mk(1, 1, 1, 1, 0, 32'h1000, 32'h10, 32'h0, 4'd5, 4'd5, 3));
    // misaligned word load, store timeout, address wrap below zero
    issue(mk(1, 1, 1, 0, 0, 32'h4000, 32'h2, 32'h0, 4'd1, 4'd2, 0));
    issue(mk(0, 1, 1, 0, 0, 32'h5000, 32'h0, 32'hCAFEF00D, 4'd3, 4'd4, NOACK));
    issue(mk(1, 1, 0, 1, 0, 32'h2, 32'h6, 32'h0, 4'd3, 4'd4, 1));

    for (int k = 0; k < 150; k++) begin
      t.load = 1'($urandom); t.pre = 1'($urandom); t.up = 1'($urandom);
      t.wb = 1'($urandom); t.byte_acc = 1'($urandom);
      t.base   = 32'h100 + $urandom_range(0, 63);
      t.offset = 32'($urandom_range(0, 15));
      if (!t.byte_acc && $urandom_range(0, 3) != 0) begin
        t.base[1:0] = 2'b00; t.offset[1:0] = 2'b00;
      end
      t.sdata = $urandom;
      t.rn    = 4'($urandom);
      t.rd    = ($urandom_range(0, 3) == 0) ? t.rn : 4'($urandom);
      t.dly   = ($urandom_range(0, 9) == 0) ? NOACK : $urandom_range(0, 3);
      issue(t);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
    end

    // Reset during the second REQ cycle aborts the access without writeback
    t = mk(1, 1, 1, 1, 0, 32'h6000, 32'h8, 32'h0, 4'd2, 4'd3, NOACK);
    model_push(t, 1'b1);
    drive(t);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; ls_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    issue(mk(1, 1, 1, 1, 0, 32'h1000, 32'h10, 32'h0, 4'd2, 4'd3, 1));

    for (int i = 0; i < 20 && (rsp_q.size() != 0 || req_q.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    chk("queues_drained", 32'(rsp_q.size() + req_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
